// File: rtl/vend_coin_encoder.sv
// Coin/cancel front end for the vending FSM: synchronizes and debounces three
// raw sensors, queues rising-edge events in a 4-deep FIFO and serializes them on {i,j}.
module vend_coin_encoder #(
  parameter int DB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_a_raw,
  input  logic       coin_b_raw,
  input  logic       cancel_raw,
  input  logic       x,
  input  logic       y,
  output logic       i,
  output logic       j,
  output logic       busy,
  output logic [2:0] pend_cnt,
  output logic       ovf
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [3:0] DB_LAST = 4'(DB_CYCLES - 1);

  // Source bit order: [0] coin A, [1] coin B, [2] cancel.
  logic [2:0] w_raw;
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [3:0] r_db_cnt [3];
  logic [3:0] w_db_cnt_nxt [3];
  logic [2:0] r_db_lvl;
  logic [2:0] w_db_lvl_nxt;
  logic [2:0] w_rise;

  logic [2:0] r_pend;
  logic [2:0] w_sel;
  logic [1:0] w_code;
  logic       w_push;
  logic       w_drop;

  logic [1:0] r_mem [4];
  logic [1:0] r_wr_ptr;
  logic [1:0] r_rd_ptr;
  logic [2:0] r_count;
  logic       w_full;
  logic       w_pop;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_ij;
  logic [1:0] w_ij_nxt;
  logic       r_ovf;

  assign w_raw = {cancel_raw, coin_b_raw, coin_a_raw};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the two synchronizer stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_db_lvl_nxt = r_db_lvl;
    w_rise       = '0;
    for (int k = 0; k < 3; k++) begin
      w_db_cnt_nxt[k] = '0;
      if (r_sync2[k] != r_db_lvl[k]) begin
        if (r_db_cnt[k] == DB_LAST) begin
          w_db_lvl_nxt[k] = r_sync2[k];
          w_rise[k]       = r_sync2[k];
        end else begin
          w_db_cnt_nxt[k] = r_db_cnt[k] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_db_lvl <= '0;
      for (int k = 0; k < 3; k++) r_db_cnt[k] <= '0;
    end else begin
      r_db_lvl <= w_db_lvl_nxt;
      for (int k = 0; k < 3; k++) r_db_cnt[k] <= w_db_cnt_nxt[k];
    end
  end

  // Highest-priority pending source is served every cycle: pushed if there is
  // room (a same-cycle pop frees a slot), otherwise dropped and flagged.
  always_comb begin
    w_sel  = 3'b000;
    w_code = 2'b00;
    if (r_pend[2]) begin
      w_sel  = 3'b100;
      w_code = 2'b11;
    end else if (r_pend[1]) begin
      w_sel  = 3'b010;
      w_code = 2'b10;
    end else if (r_pend[0]) begin
      w_sel  = 3'b001;
      w_code = 2'b01;
    end
  end

  assign w_full = (r_count == 3'd4);
  assign w_push = (|r_pend) && (!w_full || w_pop);
  assign w_drop = (|r_pend) && w_full && !w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~w_sel) | w_rise;
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  // NOTE: the FIFO storage is not reset; the pointers and count define which
  // entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_code;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Transmit FSM: the code is loaded into the output register on the
  // IDLE->DRIVE edge, and cleared again on the DRIVE->GAP edge.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_ij_nxt    = 2'b00;
    case (r_state)
      ST_IDLE: begin
        if ((r_count != 3'd0) && !x && !y) begin
          w_pop       = 1'b1;
          w_ij_nxt    = r_mem[r_rd_ptr];
          w_state_nxt = ST_DRIVE;
        end
      end
      ST_DRIVE: w_state_nxt = ST_GAP;
      ST_GAP:   w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ij    <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_ij    <= w_ij_nxt;
    end
  end

  assign i        = r_ij[1];
  assign j        = r_ij[0];
  assign busy     = (r_state != ST_IDLE);
  assign pend_cnt = r_count;
  assign ovf      = r_ovf;

endmodule

// File: doc/vend_coin_encoder.md
VEND_COIN_ENCODER -- requirements
Module: vend_coin_encoder

Interface
REQ-001 Parameter: DB_CYCLES, 4, number of consecutive stable synchronized samples required to accept a new raw input level (range 2..15).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: coin_a_raw  input  1  asynchronous low-value coin sensor, active-high.
REQ-005 Port: coin_b_raw  input  1  asynchronous high-value coin sensor, active-high.
REQ-006 Port: cancel_raw  input  1  asynchronous cancel/return button, active-high.
REQ-007 Port: x  input  1  vending FSM dispense output; stall feedback.
REQ-008 Port: y  input  1  vending FSM change output; stall feedback.
REQ-009 Port: i  output  1  coded-event bit 1 to vending FSM.
REQ-010 Port: j  output  1  coded-event bit 0 to vending FSM.
REQ-011 Port: busy  output  1  high while FSM is not IDLE.
REQ-012 Port: pend_cnt  output  3  number of queued events, 0..4.
REQ-013 Port: ovf  output  1  sticky flag: an event was dropped.

Function
REQ-014 Each raw input SHALL pass a 2-flop synchronizer, then a per-input debounce counter; the debounced level SHALL change only after DB_CYCLES consecutive synchronized samples differ from it; any mismatch-free sample SHALL clear the counter.
REQ-015 A 0->1 transition of a debounced level SHALL raise that source's pending bit for exactly one event; 1->0 transitions SHALL generate nothing.
REQ-016 Event codes {i,j} SHALL be: 00 idle, 01 coin A, 10 coin B, 11 cancel.
REQ-017 A 4-entry FIFO of 2-bit codes SHALL hold events; at most one push per cycle, priority cancel > B > A; unserved pending bits SHALL persist to later cycles.
REQ-018 Push while FIFO full SHALL drop the highest-priority pending event, clear its pending bit, and set ovf; ovf SHALL stay set until reset.
REQ-019 Simultaneous push and pop SHALL both occur; pend_cnt unchanged.
REQ-020 Transmit FSM states: IDLE, DRIVE, GAP.
REQ-021 IDLE -> DRIVE when FIFO non-empty and x=0 and y=0; pops head entry on the transition; otherwise stay IDLE.
REQ-022 DRIVE SHALL present the popped code on {i,j} for exactly one cycle, then go to GAP unconditionally (x/y ignored once in DRIVE).
REQ-023 GAP SHALL drive {i,j}=00 for exactly one cycle, then return to IDLE; back-to-back events are therefore spaced 2 cycles minimum.
REQ-024 {i,j} SHALL be registered outputs, 00 in IDLE and GAP.
REQ-025 Latency: raw rising, held stable, FIFO empty, IDLE, x=y=0 -> {i,j} valid 2+DB_CYCLES+2 rising edges after the first edge sampling raw high.
REQ-026 x or y high in IDLE SHALL stall transmission; queued events stay queued.

Reset
REQ-027 rst high SHALL immediately force i=0, j=0, busy=0, pend_cnt=0, ovf=0, FSM to IDLE, FIFO empty, pending bits, synchronizers, debounce counters and debounced levels to 0.
REQ-028 Reset mid-DRIVE SHALL abort the event with no later retransmission.
REQ-029 A raw input held high across reset release SHALL produce exactly one event after synchronization and debounce.

Verification
REQ-030 Single coin: DB_CYCLES=4, coin_a_raw pulse 10 cycles -> {i,j}=01 for one cycle at edge 8, then 00; busy high 2 cycles; pend_cnt 1->0.
REQ-031 Glitch reject: coin_b_raw high 3 cycles -> no event, pend_cnt stays 0.
REQ-032 Simultaneous: cancel, coin_b, coin_a debounced same cycle -> sequence 11, 00, 10, 00, 01, 00 on {i,j}.
REQ-033 Stall: queue 2 events with y=1 held 20 cycles -> {i,j}=00, pend_cnt=2 throughout; after y=0, both emitted in order.
REQ-034 Overflow: x=1, five distinct coin events -> pend_cnt=4, ovf=1, fifth event lost; after x=0 four events emitted; ovf stays 1.
REQ-035 Async reset: assert rst mid-DRIVE, between clock edges -> {i,j}=00, pend_cnt=0 before next edge; no event after release.
